// File: rtl/counter_run_controller.sv
// rtl/counter_run_controller.sv - run controller sequencing an N-bit counter with prescaled ticks
// Config is latched at start; all outputs come from registers.
module counter_run_controller #(
  parameter int N          = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic [N-1:0]          limit,
  input  logic                  dir,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [N-1:0]          count,
  output logic                  busy,
  output logic                  paused,
  output logic                  tc,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [N-1:0]          count_q, count_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [N-1:0]          lim_q, lim_d;
  logic                  dir_q, dir_d;
  logic                  ar_q, ar_d;
  logic [PRESCALE_W-1:0] ps_q, ps_d;
  logic                  tc_q, tc_d;
  logic                  busy_q, busy_d;
  logic                  paused_q, paused_d;
  logic                  done_q, done_d;
  logic                  tick;
  logic [N-1:0]          terminal;

  assign tick     = (pre_q == ps_q);
  assign terminal = dir_q ? '0 : lim_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    lim_d   = lim_q;
    dir_d   = dir_q;
    ar_d    = ar_q;
    ps_d    = ps_q;
    tc_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (stop) begin
          state_d = S_IDLE;
          count_d = '0;
          pre_d   = '0;
        end else if (start) begin
          state_d = S_RUN;
          lim_d   = limit;
          dir_d   = dir;
          ar_d    = auto_reload;
          ps_d    = prescale;
          count_d = dir ? limit : '0;
          pre_d   = '0;
        end
      end
      S_RUN, S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          count_d = '0;
          pre_d   = '0;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else begin
          // Leaving PAUSE counts on the same edge so a pause costs exactly its length.
          state_d = S_RUN;
          pre_d   = tick ? '0 : pre_q + 1'b1;
          if (tick) begin
            if (count_q == terminal) begin
              tc_d = 1'b1;
              if (ar_q) begin
                count_d = dir_q ? lim_q : '0;
              end else begin
                state_d = S_DONE;
              end
            end else begin
              count_d = dir_q ? count_q - 1'b1 : count_q + 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d == S_RUN) || (state_d == S_PAUSE);
    paused_d = (state_d == S_PAUSE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      pre_q    <= '0;
      lim_q    <= '0;
      dir_q    <= 1'b0;
      ar_q     <= 1'b0;
      ps_q     <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      pre_q    <= pre_d;
      lim_q    <= lim_d;
      dir_q    <= dir_d;
      ar_q     <= ar_d;
      ps_q     <= ps_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      paused_q <= paused_d;
      done_q   <= done_d;
    end
  end

  assign count  = count_q;
  assign busy   = busy_q;
  assign paused = paused_q;
  assign tc     = tc_q;
  assign done   = done_q;

endmodule

// File: doc/counter_run_controller.md
Name: counter_run_controller

Overview:
Run controller that sequences an N-bit counter datapath. Provides start/stop/pause, up or down direction, programmable limit, clock-enable prescaling and one-shot or auto-reload operation. Config inputs are latched at start, so upstream logic can change them freely while a run is in progress. Sits between control logic and the counter it drives, and reports terminal-count events and run status.

Parameters:
N, 4, counter width in bits
PRESCALE_W, 4, width of prescale divider field

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  start request (sampled each clk)
stop  input  1  abort request (sampled each clk)
pause  input  1  level; freezes counting while high in RUN
limit  input  N  terminal/reload value, latched at start
dir  input  1  0 = count up 0->limit, 1 = count down limit->0; latched at start
auto_reload  input  1  1 = reload and continue at terminal, 0 = one-shot; latched at start
prescale  input  PRESCALE_W  tick every prescale+1 clocks; latched at start
count  output  N  current count value (registered)
busy  output  1  high in RUN or PAUSE
paused  output  1  high in PAUSE
tc  output  1  one-cycle pulse on terminal-count tick
done  output  1  level, high in DONE (one-shot finished)

Behaviour:
- Reset (async, any state):
  - state = IDLE.
  - count = 0, prescaler = 0.
  - busy = paused = tc = done = 0.
  - Latched config registers = 0.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Priority on any edge: stop > start > pause.
- IDLE:
  - start = 1 -> RUN.
  - Latch limit, dir, auto_reload and prescale.
  - count = 0 if dir = 0, else count = limit.
  - Prescaler cleared; busy = 1 from that edge.
- RUN:
  - Prescaler counts 0..prescale; a tick occurs on the clock where prescaler == prescale, then the prescaler wraps to 0.
  - Tick with count != terminal (terminal = limit when up, 0 when down): count +1 (up) or -1 (down). No wrap is possible inside the range.
  - Tick with count == terminal: tc = 1 for exactly one cycle.
    - auto_reload = 1: count reloads to its start value (0 up, limit down); stay in RUN.
    - auto_reload = 0: -> DONE; count holds terminal; busy = 0; done = 1.
  - The terminal value is held for one full tick period before tc.
  - Auto-reload tc period = (limit+1)*(prescale+1) clocks.
  - start while in RUN is ignored; config input changes are ignored.
  - pause = 1 -> PAUSE. count and prescaler are frozen; the tick that would fire on that edge is suppressed.
- PAUSE:
  - paused = 1, busy = 1.
  - pause = 0 -> RUN, resuming with the same prescaler phase.
- DONE:
  - done = 1 (level).
  - start -> RUN with a fresh latch, exactly as from IDLE; done clears on the same edge.
- stop in RUN, PAUSE or DONE:
  - -> IDLE; count = 0, prescaler = 0.
  - busy = paused = done = 0; tc = 0.
  - Any pending terminal tick is discarded.
- stop and start asserted on the same edge: stop wins and the start is dropped.
- limit = 0: the first tick is a terminal tick, so tc fires after prescale+1 clocks in RUN.
- Reset mid-run: immediate return to the reset values; no tc is emitted.

Test Plan:
1. One-shot up count. N=4, prescale=0, limit=5, dir=0, auto_reload=0, start pulsed at edge 0.
   -> count = 0 after edge 0, then 1..5 on edges 1–5.
   -> Edge 6: tc = 1, done = 1, busy = 0, count = 5.
   -> Edge 7: tc = 0.
2. Auto-reload down count. limit=3, dir=1, prescale=1, auto_reload=1.
   -> count sequence 3,3,2,2,1,1,0,0,3,...
   -> tc pulses every 8 clocks, one cycle wide; busy stays 1.
3. Pause. As scenario 1, with pause held high for 4 clocks when count = 2.
   -> count stays 2 and paused = 1 for 4 clocks.
   -> Counting resumes; tc arrives 4 clocks later than in scenario 1.
4. Stop precedence. stop and start asserted together in RUN at count = 3.
   -> Next edge: IDLE, count = 0, busy = 0, no tc.
   -> A later start alone restarts from 0.
5. limit=0 and config isolation.
   - limit=0, prescale=2, dir=0, one-shot -> tc and done 3 clocks after start, count = 0.
   - A separate run with limit=5: change limit to 9 mid-run -> terminal still at 5.
6. Async reset. Assert reset between clock edges while count = 4.
   -> Outputs go to 0 immediately, without waiting for a clock edge.
   -> Deassert reset, then start -> normal sequence resumes from scenario 1 timing.
